// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register (output register + skid
// register). Full throughput, one-cycle latency, all outputs decoded from
// registered state so no combinational ready/valid path crosses the block.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic acc;
  logic emit;

  assign acc  = in_valid & in_ready;
  assign emit = out_valid & out_ready;

  // State and data registers; rst has top priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= RST_VAL;
      skid_q  <= RST_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next occupancy and data-register loads; flush mirrors reset and drops any word accepted that cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RST_VAL;
      skid_d  = RST_VAL;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (acc && emit) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of the skid entry can happen.
          if (emit) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs decoded purely from the registered occupancy.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    count     = 2'd0;
    unique case (state_q)
      EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        count     = 2'd0;
      end
      BUSY: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
        count     = 2'd1;
      end
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        count     = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        count     = 2'd0;
      end
    endcase
  end

  assign out_data = main_q;

  // Structural invariants of the occupancy encoding.
  a_full_not_ready : assert property (@(posedge clk) (count == 2'd2) |-> !in_ready);
  a_valid_count    : assert property (@(posedge clk) out_valid == (count != 2'd0));
  a_no_spurious_fill : assert property (@(posedge clk) disable iff (rst || flush)
    (state_q == BUSY && !acc) |=> (state_q != FULL));

endmodule
